// File: rtl/shift_pkg.sv
//------------------------------------------------------------------------------
// Module      : shift_pkg
// Description : Shared op encodings and FSM state enumeration for shift_scheduler.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_scheduler_if.sv
//------------------------------------------------------------------------------
// Module      : shift_scheduler_if
// Description : Two requester channels and one response channel of shift_scheduler.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface shift_scheduler_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [AMT_W-1:0] req0_amt;
    logic [1:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [AMT_W-1:0] req1_amt;
    logic [1:0]       req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;

    modport master (
        output req0_valid, req0_data, req0_amt, req0_op,
        output req1_valid, req1_data, req1_amt, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_op,
        input  req1_valid, req1_data, req1_amt, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

`default_nettype wire

// File: rtl/rr_arb2.sv
//------------------------------------------------------------------------------
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with one-hot grant and last-grant register.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [1:0] i_req,
    input  wire logic       i_advance,
    output logic      [1:0] o_grant
);

    // 1 means requester 1 won last, so requester 0 is favoured next
    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= 1'b1;
        end else if (i_advance) begin
            r_last <= o_grant[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_scheduler.sv
//------------------------------------------------------------------------------
// Module      : shift_scheduler
// Description : Arbitrates two requesters and shifts one operand a bit per cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_scheduler
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    shift_scheduler_if.slave  bus
);

    localparam int C_CNT_W = $clog2(WIDTH + 1);

    state_e               r_state,  w_state_nxt;
    logic [WIDTH-1:0]     r_work,   w_work_nxt;
    logic [C_CNT_W-1:0]   r_count,  w_count_nxt;
    shift_op_e            r_op,     w_op_nxt;
    logic                 r_id,     w_id_nxt;

    logic [1:0]           w_req;
    logic [1:0]           w_grant;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_sel_data;
    logic [AMT_W-1:0]     w_sel_amt;
    shift_op_e            w_sel_op;
    logic [C_CNT_W-1:0]   w_sel_count;

    assign w_req    = (r_state == IDLE) ? {bus.req1_valid, bus.req0_valid} : 2'b00;
    assign w_accept = |w_grant;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (w_req),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    assign w_sel_data = w_grant[1] ? bus.req1_data : bus.req0_data;
    assign w_sel_amt  = w_grant[1] ? bus.req1_amt  : bus.req0_amt;
    assign w_sel_op   = w_grant[1] ? shift_op_e'(bus.req1_op) : shift_op_e'(bus.req0_op);

    // Amounts past the operand width saturate: the bit-serial shift then flushes it
    always_comb begin
        if (w_sel_op == OP_PASS) begin
            w_sel_count = '0;
        end else if (32'(w_sel_amt) >= 32'(WIDTH)) begin
            w_sel_count = C_CNT_W'(WIDTH);
        end else begin
            w_sel_count = C_CNT_W'(w_sel_amt);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_count_nxt = r_count;
        w_op_nxt    = r_op;
        w_id_nxt    = r_id;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_work_nxt  = w_sel_data;
                    w_count_nxt = w_sel_count;
                    w_op_nxt    = w_sel_op;
                    w_id_nxt    = w_grant[1];
                    w_state_nxt = (w_sel_count == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // SRA never changes the MSB, so it still holds the original sign
                case (r_op)
                    OP_SLL:  w_work_nxt = {r_work[WIDTH-2:0], 1'b0};
                    OP_SRL:  w_work_nxt = {1'b0, r_work[WIDTH-1:1]};
                    OP_SRA:  w_work_nxt = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
                    default: w_work_nxt = r_work;
                endcase
                w_count_nxt = r_count - 1'b1;
                if (r_count <= C_CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_count <= '0;
            r_op    <= OP_PASS;
            r_id    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_count <= w_count_nxt;
            r_op    <= w_op_nxt;
            r_id    <= w_id_nxt;
        end
    end

    assign bus.req0_ready = reset & w_grant[0];
    assign bus.req1_ready = reset & w_grant[1];
    assign bus.rsp_valid  = (r_state == DONE);
    assign bus.rsp_data   = (r_state == DONE) ? r_work : '0;
    assign bus.rsp_id     = r_id;

endmodule

`default_nettype wire

// File: tb/tb_shift_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_shift_scheduler
// Description : Directed self-checking bench for shift_scheduler (WIDTH=4, AMT_W=4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_scheduler;

    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;

    shift_scheduler_if #(.WIDTH(4), .AMT_W(4)) bus ();

    shift_scheduler #(.WIDTH(4), .AMT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic [1:0] op,
                           input logic [3:0] data, input logic [3:0] amt);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_data = data; bus.req0_amt = amt;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_data = data; bus.req1_amt = amt;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Present one job, then count cycles from the accept cycle to rsp_valid
    task automatic run_job(input string tag, input int n, input logic [1:0] op,
                           input logic [3:0] data, input logic [3:0] amt,
                           input logic [3:0] exp_data, input int exp_lat);
        int lat;
        @(negedge clk);
        set_req(n, 1'b1, op, data, amt);
        #1;
        chk({tag, "_ready"}, (n == 0) ? bus.req0_ready : bus.req1_ready, 1);
        @(negedge clk);
        set_req(n, 1'b0, 2'b00, 4'h0, 4'h0);
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, bus.rsp_data, exp_data);
        chk({tag, "_id"}, bus.rsp_id, n);
    endtask

    initial begin
        int g_n;
        int r_n;
        int seen;
        vec_cnt = 0;
        err_cnt = 0;
        reset   = 1'b0;
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 2'b11, 4'h5, 4'h0);
        set_req(1, 1'b0, 2'b00, 4'h0, 4'h0);
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_req0_ready", bus.req0_ready, 0);
        repeat (2) @(negedge clk);
        set_req(0, 1'b0, 2'b00, 4'h0, 4'h0);
        reset = 1'b1;

        run_job("srl_0011_1", 0, 2'b01, 4'b0011, 4'd1,  4'b0001, 2);
        run_job("sra_1110_1", 1, 2'b10, 4'b1110, 4'd1,  4'b1111, 2);
        run_job("srl_1110_1", 1, 2'b01, 4'b1110, 4'd1,  4'b0111, 2);
        run_job("sll_1110_0", 1, 2'b00, 4'b1110, 4'd0,  4'b1110, 1);
        run_job("sra_1000_f", 0, 2'b10, 4'b1000, 4'd15, 4'b1111, 5);
        run_job("sll_1000_f", 0, 2'b00, 4'b1000, 4'd15, 4'b0000, 5);
        run_job("srl_1000_2", 0, 2'b01, 4'b1000, 4'd2,  4'b0010, 3);
        run_job("pass_1011_3", 1, 2'b11, 4'b1011, 4'd3, 4'b1011, 1);
        run_job("sll_0011_2", 1, 2'b00, 4'b0011, 4'd2,  4'b1100, 3);

        // Both requesters continuously valid from reset: grants alternate 0,1,0,1
        do_reset();
        set_req(0, 1'b1, 2'b11, 4'b0101, 4'd0);
        set_req(1, 1'b1, 2'b11, 4'b1010, 4'd0);
        g_n = 0;
        r_n = 0;
        for (int cyc = 0; cyc < 40 && (g_n < 4 || r_n < 4); cyc++) begin
            #1;
            if (bus.rsp_valid) begin
                chk("rr_rsp_id", bus.rsp_id, r_n % 2);
                chk("rr_rsp_data", bus.rsp_data, (r_n % 2 == 0) ? 4'b0101 : 4'b1010);
                r_n++;
            end
            if (bus.req0_ready || bus.req1_ready) begin
                chk("rr_grant", {bus.req1_ready, bus.req0_ready}, (g_n % 2 == 0) ? 2'b01 : 2'b10);
                g_n++;
            end
            @(negedge clk);
        end
        chk("rr_grant_count", g_n >= 4, 1);
        chk("rr_rsp_count", r_n >= 4, 1);
        set_req(0, 1'b0, 2'b00, 4'h0, 4'h0);
        set_req(1, 1'b0, 2'b00, 4'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);

        // Consumer stalls for three cycles in DONE
        bus.rsp_ready = 1'b0;
        run_job("stall_sll", 0, 2'b00, 4'b0011, 4'd1, 4'b0110, 2);
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, 2'b00, 4'h1, 4'h0);
            set_req(1, 1'b1, 2'b00, 4'h2, 4'h0);
            #1;
            chk("stall_valid", bus.rsp_valid, 1);
            chk("stall_data", bus.rsp_data, 4'b0110);
            chk("stall_id", bus.rsp_id, 0);
            chk("stall_readys", {bus.req1_ready, bus.req0_ready}, 2'b00);
            @(negedge clk);
        end
        set_req(1, 1'b0, 2'b00, 4'h0, 4'h0);
        bus.rsp_ready = 1'b1;
        #1;
        chk("exit_req0_ready", bus.req0_ready, 0);
        #1;
        set_req(0, 1'b0, 2'b00, 4'h0, 4'h0);
        @(negedge clk);
        chk("exit_valid", bus.rsp_valid, 0);
        chk("exit_data", bus.rsp_data, 0);

        // Reset in the middle of an amt=3 shift; last grant was req0 beforehand
        @(negedge clk);
        set_req(0, 1'b1, 2'b01, 4'b1000, 4'd3);
        #1;
        chk("mid_ready", bus.req0_ready, 1);
        @(negedge clk);
        set_req(0, 1'b0, 2'b00, 4'h0, 4'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", bus.rsp_valid, 0);
        chk("mid_rst_data", bus.rsp_data, 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("mid_no_rsp", seen, 0);
        set_req(0, 1'b1, 2'b11, 4'b1001, 4'd0);
        set_req(1, 1'b1, 2'b11, 4'b0110, 4'd0);
        #1;
        chk("post_rst_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(negedge clk);
        set_req(0, 1'b0, 2'b00, 4'h0, 4'h0);
        set_req(1, 1'b0, 2'b00, 4'h0, 4'h0);
        #1;
        chk("post_rst_data", bus.rsp_data, 4'b1001);
        chk("post_rst_id", bus.rsp_id, 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
